// File: rtl/prol16_bus_monitor.sv
// Passive PROL16 memory-bus monitor: rebuilds read/write transactions and queues them for a consumer.
// Latency: close -> FIFO push 1 edge; push into empty FIFO -> txn_valid_o 1 further edge (registered head).
// Backpressure: txn_ready_i low holds the head stable; a push into a full FIFO is dropped and flagged.
module prol16_bus_monitor #(
  parameter int gDataWidth = 16,
  parameter int gFifoDepth = 4,
  parameter int gCntWidth  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [gDataWidth-1:0] mem_addr_i,
  input  logic [gDataWidth-1:0] mem_rdata_i,
  input  logic [gDataWidth-1:0] mem_wdata_i,
  input  logic                  mem_ce_ni,
  input  logic                  mem_oe_ni,
  input  logic                  mem_we_ni,
  input  logic                  illegal_inst_i,
  input  logic                  cpu_halt_i,
  output logic                  txn_valid_o,
  input  logic                  txn_ready_i,
  output logic                  txn_write_o,
  output logic [gDataWidth-1:0] txn_addr_o,
  output logic [gDataWidth-1:0] txn_data_o,
  output logic [gCntWidth-1:0]  rd_count_o,
  output logic [gCntWidth-1:0]  wr_count_o,
  output logic                  overflow_o,
  output logic                  bus_err_o,
  output logic                  halted_o,
  output logic                  illegal_o
);

  // Pointer width and occupancy width (occupancy must reach gFifoDepth itself).
  localparam int PW = (gFifoDepth > 1) ? $clog2(gFifoDepth) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        DEPTH   = CW'(gFifoDepth);
  localparam logic [gCntWidth-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                  write;
    logic [gDataWidth-1:0] addr;
    logic [gDataWidth-1:0] data;
  } txn_t;

  // ---------------------------------------------------------------------------
  // Bus cycle classification
  // ---------------------------------------------------------------------------
  logic cyc_rd;
  logic cyc_wr;
  logic cyc_err;
  logic cyc_act;

  // Decode the sampled strobes into READ / WRITE / ERR; everything else is idle.
  always_comb begin
    cyc_rd  = ~mem_ce_ni & ~mem_oe_ni &  mem_we_ni;
    cyc_wr  = ~mem_ce_ni &  mem_oe_ni & ~mem_we_ni;
    cyc_err = ~mem_ce_ni & ~mem_oe_ni & ~mem_we_ni;
    cyc_act = cyc_rd | cyc_wr;
  end

  // ---------------------------------------------------------------------------
  // Capture stage: one open transaction
  // ---------------------------------------------------------------------------
  txn_t open_q;
  txn_t open_d;
  txn_t cur_rec;
  logic open_vld_q;
  logic open_vld_d;
  logic same_txn;
  logic close_txn;
  logic halted_q;
  logic halted_d;

  // Decide whether this cycle extends, closes and/or opens a transaction.
  // A halt closes the open record as it stands and blocks any open in the same cycle.
  always_comb begin
    cur_rec.write = cyc_wr;
    cur_rec.addr  = mem_addr_i;
    cur_rec.data  = cyc_wr ? mem_wdata_i : mem_rdata_i;
    same_txn      = open_vld_q & cyc_act & (open_q.write == cyc_wr) &
                    (open_q.addr == mem_addr_i);
    close_txn     = open_vld_q & (~same_txn | cpu_halt_i);
    // Extending and opening both end with the current cycle in the record.
    open_vld_d    = cyc_act & ~halted_q & ~cpu_halt_i;
    open_d        = open_vld_d ? cur_rec : open_q;
    halted_d      = halted_q | cpu_halt_i;
  end

  // Open-record register.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_vld_q <= 1'b0;
      open_q     <= '0;
    end else begin
      open_vld_q <= open_vld_d;
      open_q     <= open_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky status
  // ---------------------------------------------------------------------------
  logic [gCntWidth-1:0] rd_cnt_q;
  logic [gCntWidth-1:0] rd_cnt_d;
  logic [gCntWidth-1:0] wr_cnt_q;
  logic [gCntWidth-1:0] wr_cnt_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 bus_err_q;
  logic                 bus_err_d;
  logic                 illegal_q;
  logic                 illegal_d;
  logic                 drop;

  // Saturating per-kind counters count every closed transaction, dropped or not.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (close_txn && !open_q.write && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (close_txn && open_q.write && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    ovf_d     = ovf_q | drop;
    bus_err_d = bus_err_q | cyc_err;
    illegal_d = illegal_q | illegal_inst_i;
  end

  // Counter and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FIFO with registered head
  // ---------------------------------------------------------------------------
  txn_t          fifo_mem [gFifoDepth];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_old;
  logic          pop;
  logic          push_ok;
  txn_t          head_q;
  txn_t          head_d;
  logic          head_vld_q;
  logic          head_vld_d;

  // Occupancy includes the entry shown at the head. The head only presents
  // entries that were already stored before this edge, so a fresh push into an
  // empty FIFO appears one edge later and the head never reads a slot being written.
  always_comb begin
    pop        = head_vld_q & txn_ready_i;
    push_ok    = close_txn & ((cnt_q != DEPTH) | pop);
    drop       = close_txn & ~push_ok;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    cnt_old    = cnt_q - CW'(pop);
    cnt_d      = cnt_old + CW'(push_ok);
    head_vld_d = (cnt_old != '0);
    head_d     = head_vld_d ? fifo_mem[rd_ptr_d] : head_q;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_mem[wr_ptr_q] <= open_q;
    end
  end

  // FIFO pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  assign txn_valid_o = head_vld_q;
  assign txn_write_o = head_q.write;
  assign txn_addr_o  = head_q.addr;
  assign txn_data_o  = head_q.data;
  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign overflow_o  = ovf_q;
  assign bus_err_o   = bus_err_q;
  assign halted_o    = halted_q;
  assign illegal_o   = illegal_q;

endmodule

// File: doc/prol16_bus_monitor.md
Name: prol16_bus_monitor

Overview:
- Passive observer on the PROL16 CPU memory bus, on the CPU side of the memory.
- Samples the CPU memory strobes, address and data every clock and reconstructs discrete read and write transactions.
- Buffers completed transactions in a small FIFO and delivers them over a valid/ready handshake to the scoreboard/reference model.
- Latches halt, illegal-instruction and bus-protocol-error status; keeps transaction counters.

Parameters:
- gDataWidth, 16, width of address and data buses (matches the CPU).
- gFifoDepth, 4, transaction FIFO entries; power of two, at least 2.
- gCntWidth, 16, width of the read and write counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_addr_i  in  gDataWidth  CPU memory address
- mem_rdata_i  in  gDataWidth  data driven by memory to the CPU
- mem_wdata_i  in  gDataWidth  data driven by the CPU to memory
- mem_ce_ni  in  1  chip enable, active low
- mem_oe_ni  in  1  output enable, active low
- mem_we_ni  in  1  write enable, active low
- illegal_inst_i  in  1  CPU illegal-instruction flag
- cpu_halt_i  in  1  CPU halt flag
- txn_valid_o  out  1  FIFO head valid
- txn_ready_i  in  1  consumer accepts head
- txn_write_o  out  1  head kind: 1 = write, 0 = read
- txn_addr_o  out  gDataWidth  head address
- txn_data_o  out  gDataWidth  head data
- rd_count_o  out  gCntWidth  completed reads, saturating
- wr_count_o  out  gCntWidth  completed writes, saturating
- overflow_o  out  1  sticky: a transaction was dropped
- bus_err_o  out  1  sticky: ce_n=0 with oe_n=0 and we_n=0 together
- halted_o  out  1  sticky halt seen
- illegal_o  out  1  sticky illegal instruction seen

Behaviour:
- Reset: all outputs 0, FIFO empty, capture stage idle. Reset mid-transaction discards the open transaction and all FIFO contents.
- Cycle classification from sampled inputs:
  - READ: ce_n=0, oe_n=0, we_n=1.
  - WRITE: ce_n=0, we_n=0, oe_n=1.
  - ERR: ce_n=0, oe_n=0, we_n=0. Sets bus_err_o; treated as IDLE for capture.
  - IDLE: all other combinations.
- Capture stage holds one open transaction: kind, addr, data.
  - On each READ/WRITE cycle the open record's addr and data are overwritten. Data comes from mem_rdata_i for reads, mem_wdata_i for writes. The last active cycle therefore wins.
  - The transaction closes when the next cycle is IDLE/ERR, or its kind differs, or its addr differs. On a kind/addr change the new cycle opens a fresh record in the same clock.
  - A closed transaction is pushed into the FIFO on the clock edge following its last active cycle. Latency: 1 cycle from close to push; txn_valid_o rises the edge after the push at the earliest when the FIFO was empty (registered head).
- FIFO:
  - Push and pop in the same cycle are allowed when full.
  - Push while full and no pop: entry dropped, overflow_o set (sticky), counters still increment.
  - Pop occurs when txn_valid_o and txn_ready_i are both 1.
  - Outputs hold stable while txn_valid_o=1 and txn_ready_i=0.
- Counters:
  - rd_count_o and wr_count_o increment by 1 per closed transaction of that kind.
  - They saturate at all-ones; no wrap.
- Halt:
  - cpu_halt_i=1 sets halted_o the next edge.
  - An open transaction is closed and pushed that same edge.
  - No new transactions are opened while halted_o=1; the FIFO still drains.
- illegal_o is set the edge after illegal_inst_i=1; sticky until rst.
- Simultaneous close, open and halt in one cycle: push the close, suppress the open.

Test Plan:
- Single read: ce_n=0, oe_n=0, addr=0x0010, rdata=0x1234 for 2 cycles, then IDLE; ready=1 → exactly one entry (write=0, addr=0x0010, data=0x1234), rd_count=1.
- Back-to-back writes: addr 0x0020, then 0x0021 on consecutive cycles, wdata 0xAAAA then 0x5555 → two entries in order, wr_count=2, no idle gap needed.
- Backpressure/overflow: ready=0, 5 distinct reads with depth 4 → first 4 held in order, overflow_o=1, rd_count=5; raising ready then drains 4 entries.
- Protocol error: ce_n=0, oe_n=0, we_n=0 for 1 cycle → bus_err_o=1, no FIFO entry, counters unchanged.
- Halt mid-read: read at 0x0030 active when cpu_halt_i=1 → entry pushed, halted_o=1; subsequent READ cycles produce no entries.
- Reset mid-operation: 3 entries queued, rst=1 for one cycle → txn_valid_o=0, counters=0, all sticky flags cleared.
